// File: rtl/stopwatch_lap_timer.sv
// stopwatch_lap_timer
//   Stopwatch / countdown core running off the 100 Hz timebase. Keeps
//   hh:mm:ss:xx as four binary fields, counts up or down depending on
//   countdown_mode, raises a timed alarm when a countdown expires and
//   records up to 2**LAP_AW lap times that can be read back by index.
//
// Ports
//   clk_100Hz, rst                  100 Hz clock, async active-high reset
//   start, stop, lap, clear         one-cycle command pulses
//   hour_inc, min_inc, sec_inc      countdown preset adjust pulses
//   countdown_mode                  level: 1 = count down, 0 = count up
//   lap_sel                         lap read index
//   hours, minutes, seconds,
//   centisec                        current time fields
//   stopped, running                decoded state
//   alarm                           high for ALARM_TICKS cycles after expiry
//   wrap                            one-cycle pulse on count-up rollover
//   lap_count, lap_full             lap buffer occupancy
//   lap_rd_data                     {h,m,s,cs} of lap[lap_sel], registered
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | cleared / freshly loaded, waiting for start
// RUNNING  | counting once per clock
// STOPPED  | frozen, start resumes from the held value
// EXPIRED  | countdown reached zero, alarm window may be active

module stopwatch_lap_timer #(
  parameter int unsigned HOUR_MAX    = 99,
  parameter int unsigned PRESET_MIN  = 1,
  parameter int unsigned LAP_AW      = 3,
  parameter int unsigned ALARM_TICKS = 200
) (
  input  logic              clk_100Hz,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              lap,
  input  logic              clear,
  input  logic              min_inc,
  input  logic              hour_inc,
  input  logic              sec_inc,
  input  logic              countdown_mode,
  input  logic [LAP_AW-1:0] lap_sel,
  output logic [7:0]        hours,
  output logic [7:0]        minutes,
  output logic [7:0]        seconds,
  output logic [7:0]        centisec,
  output logic              stopped,
  output logic              running,
  output logic              alarm,
  output logic              wrap,
  output logic [LAP_AW:0]   lap_count,
  output logic              lap_full,
  output logic [31:0]       lap_rd_data
);

  localparam int unsigned    LAP_DEPTH    = 1 << LAP_AW;
  localparam logic [LAP_AW:0] LAP_DEPTH_C = (LAP_AW+1)'(LAP_DEPTH);
  localparam logic [7:0]     HOUR_MAX_C   = 8'(HOUR_MAX);
  localparam logic [7:0]     PRESET_C     = 8'(PRESET_MIN);
  localparam int             ACW          = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
  localparam logic [ACW-1:0] ALARM_RELOAD = ACW'(ALARM_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUNNING,
    ST_STOPPED,
    ST_EXPIRED
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       h_q, h_d, m_q, m_d, s_q, s_d, cs_q, cs_d;
  logic             mode_q, mode_d;
  logic             alarm_q, alarm_d;
  logic [ACW-1:0]   alarm_cnt_q, alarm_cnt_d;
  logic             wrap_q, wrap_d;
  logic [LAP_AW:0]  lap_count_q, lap_count_d;
  logic [31:0]      lap_rd_data_q, lap_rd_data_d;
  logic [31:0]      lap_mem_q [LAP_DEPTH];
  logic             lap_we;

  logic mode_rise, mode_fall, time_zero, time_one, start_ok, full_w;

  assign mode_rise = countdown_mode & ~mode_q;
  assign mode_fall = ~countdown_mode & mode_q;
  assign time_zero = (h_q == 8'd0) && (m_q == 8'd0) && (s_q == 8'd0) && (cs_q == 8'd0);
  assign time_one  = (h_q == 8'd0) && (m_q == 8'd0) && (s_q == 8'd0) && (cs_q == 8'd1);
  assign full_w    = (lap_count_q == LAP_DEPTH_C);
  // A countdown with nothing loaded would expire instantly, so start is
  // treated as absent in that case.
  assign start_ok  = start && (state_q == ST_IDLE || state_q == ST_STOPPED) &&
                     !(countdown_mode && time_zero);

  always_comb begin
    state_d       = state_q;
    h_d           = h_q;
    m_d           = m_q;
    s_d           = s_q;
    cs_d          = cs_q;
    mode_d        = countdown_mode;
    alarm_d       = alarm_q;
    alarm_cnt_d   = alarm_cnt_q;
    wrap_d        = 1'b0;
    lap_count_d   = lap_count_q;
    lap_we        = 1'b0;
    lap_rd_data_d = ({1'b0, lap_sel} < lap_count_q) ? lap_mem_q[lap_sel] : 32'd0;

    // Alarm window: down-counter, alarm drops at terminal count.
    if (alarm_q) begin
      if (alarm_cnt_q == '0) alarm_d = 1'b0;
      else                   alarm_cnt_d = alarm_cnt_q - 1'b1;
    end

    if (mode_rise || mode_fall) begin
      h_d     = 8'd0;
      m_d     = mode_rise ? PRESET_C : 8'd0;
      s_d     = 8'd0;
      cs_d    = 8'd0;
      state_d = ST_IDLE;
      alarm_d = 1'b0;
    end else if (clear && state_q != ST_RUNNING) begin
      h_d         = 8'd0;
      m_d         = countdown_mode ? PRESET_C : 8'd0;
      s_d         = 8'd0;
      cs_d        = 8'd0;
      lap_count_d = '0;
      state_d     = ST_IDLE;
      alarm_d     = 1'b0;
    end else if (stop && state_q == ST_RUNNING) begin
      state_d = ST_STOPPED;
    end else if (start && state_q == ST_EXPIRED) begin
      state_d = ST_IDLE;
      alarm_d = 1'b0;
    end else if (start_ok) begin
      state_d = ST_RUNNING;
    end else if (state_q == ST_RUNNING) begin
      // Lap captures the value on the outputs this cycle, before the tick.
      if (lap && !full_w) begin
        lap_we      = 1'b1;
        lap_count_d = lap_count_q + 1'b1;
      end
      if (countdown_mode) begin
        if (!time_zero) begin
          if (cs_q != 8'd0) begin
            cs_d = cs_q - 1'b1;
          end else begin
            cs_d = 8'd99;
            if (s_q != 8'd0) begin
              s_d = s_q - 1'b1;
            end else begin
              s_d = 8'd59;
              if (m_q != 8'd0) begin
                m_d = m_q - 1'b1;
              end else begin
                m_d = 8'd59;
                h_d = h_q - 1'b1;
              end
            end
          end
          if (time_one) begin
            state_d     = ST_EXPIRED;
            alarm_d     = 1'b1;
            alarm_cnt_d = ALARM_RELOAD;
          end
        end
      end else begin
        if (cs_q != 8'd99) begin
          cs_d = cs_q + 1'b1;
        end else begin
          cs_d = 8'd0;
          if (s_q != 8'd59) begin
            s_d = s_q + 1'b1;
          end else begin
            s_d = 8'd0;
            if (m_q != 8'd59) begin
              m_d = m_q + 1'b1;
            end else begin
              m_d = 8'd0;
              if (h_q >= HOUR_MAX_C) begin
                h_d    = 8'd0;
                wrap_d = 1'b1;
              end else begin
                h_d = h_q + 1'b1;
              end
            end
          end
        end
      end
    end else if (countdown_mode && (state_q == ST_IDLE || state_q == ST_STOPPED)) begin
      // Preset adjust: fields wrap independently, no carry.
      if (hour_inc) h_d = (h_q >= HOUR_MAX_C) ? 8'd0 : h_q + 1'b1;
      if (min_inc)  m_d = (m_q >= 8'd59) ? 8'd0 : m_q + 1'b1;
      if (sec_inc)  s_d = (s_q >= 8'd59) ? 8'd0 : s_q + 1'b1;
    end
  end

  always_ff @(posedge clk_100Hz or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      h_q           <= 8'd0;
      m_q           <= 8'd0;
      s_q           <= 8'd0;
      cs_q          <= 8'd0;
      mode_q        <= 1'b0;
      alarm_q       <= 1'b0;
      alarm_cnt_q   <= '0;
      wrap_q        <= 1'b0;
      lap_count_q   <= '0;
      lap_rd_data_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      m_q           <= m_d;
      s_q           <= s_d;
      cs_q          <= cs_d;
      mode_q        <= mode_d;
      alarm_q       <= alarm_d;
      alarm_cnt_q   <= alarm_cnt_d;
      wrap_q        <= wrap_d;
      lap_count_q   <= lap_count_d;
      lap_rd_data_q <= lap_rd_data_d;
    end
  end

  // Lap storage needs no reset: entries at or above lap_count read as zero.
  always_ff @(posedge clk_100Hz) begin
    if (lap_we) lap_mem_q[lap_count_q[LAP_AW-1:0]] <= {h_q, m_q, s_q, cs_q};
  end

  assign hours       = h_q;
  assign minutes     = m_q;
  assign seconds     = s_q;
  assign centisec    = cs_q;
  assign stopped     = (state_q == ST_STOPPED);
  assign running     = (state_q == ST_RUNNING);
  assign alarm       = alarm_q;
  assign wrap        = wrap_q;
  assign lap_count   = lap_count_q;
  assign lap_full    = full_w;
  assign lap_rd_data = lap_rd_data_q;

endmodule
